// File: rtl/xadc_sample_monitor.sv
// Paces XADC conversions, block-averages the returned samples and raises a hysteretic alarm.
// Optional min/max sample tracking is compiled in when XADC_MONITOR_MINMAX_EN is defined.
module xadc_sample_monitor #(
    parameter int AVG_LOG2    = 3,
    parameter int TRIG_PERIOD = 100000,
    parameter int DATA_W      = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    output logic              trigger,
    input  logic              Sample_Valid,
    input  logic [15:0]       ADC_Data_in,
    input  logic [DATA_W-1:0] Thresh_Hi,
    input  logic [DATA_W-1:0] Thresh_Lo,
    input  logic              Clear_Overrun,
    output logic [DATA_W-1:0] Avg_Out,
    output logic              Avg_Valid,
    output logic              Alarm,
`ifdef XADC_MONITOR_MINMAX_EN
    output logic [DATA_W-1:0] Min_Out,
    output logic [DATA_W-1:0] Max_Out,
`endif
    output logic              Overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = $clog2(TRIG_PERIOD);
    localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(TRIG_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        WT_TICK,
        TRIG,
        WT_SAMPLE,
        ACCUM,
        UPDATE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] count_q, count_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                alarm_q, alarm_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic [DATA_W-1:0]   avg_new;
    logic                unused_adc_bits;

    // Only the top DATA_W bits of the DRP word carry the conversion result.
    assign unused_adc_bits = ^ADC_Data_in[15-DATA_W:0];

    assign tick    = Enable && (period_q == TICK_VAL);
    assign avg_new = acc_q[ACC_W-1:AVG_LOG2];

    always_comb begin
        period_d = '0;
        if (Enable && (period_q != TICK_VAL)) begin
            period_d = period_q + CNT_W'(1);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        acc_d       = acc_q;
        count_d     = count_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        alarm_d     = alarm_q;
        overrun_d   = overrun_q;

        // A set event later in this block overrides the clear.
        if (Clear_Overrun) begin
            overrun_d = 1'b0;
        end

        if (!Enable) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WT_TICK;
                end
                WT_TICK: begin
                    if (tick) begin
                        state_d = TRIG;
                    end
                end
                TRIG: begin
                    state_d = WT_SAMPLE;
                end
                WT_SAMPLE: begin
                    if (Sample_Valid) begin
                        sample_d = ADC_Data_in[15 -: DATA_W];
                        state_d  = ACCUM;
                    end else if (tick) begin
                        overrun_d = 1'b1;
                    end
                end
                ACCUM: begin
                    acc_d   = acc_q + ACC_W'(sample_q);
                    count_d = count_q + AVG_LOG2'(1);
                    state_d = (count_q == '1) ? UPDATE : WT_TICK;
                end
                UPDATE: begin
                    avg_d       = avg_new;
                    avg_valid_d = 1'b1;
                    if (avg_new > Thresh_Hi) begin
                        alarm_d = 1'b1;
                    end else if (avg_new < Thresh_Lo) begin
                        alarm_d = 1'b0;
                    end
                    acc_d   = '0;
                    state_d = WT_TICK;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            period_q    <= '0;
            sample_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            sample_q    <= sample_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
            overrun_q   <= overrun_d;
        end
    end

    assign trigger   = (state_q == TRIG);
    assign Avg_Out   = avg_q;
    assign Avg_Valid = avg_valid_q;
    assign Alarm     = alarm_q;
    assign Overrun   = overrun_q;

`ifdef XADC_MONITOR_MINMAX_EN
    logic [DATA_W-1:0] min_q, max_q;

    // Tracks every sample reaching ACCUM since reset; Enable does not clear these.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            min_q <= '1;
            max_q <= '0;
        end else if (state_q == ACCUM) begin
            if (sample_q < min_q) begin
                min_q <= sample_q;
            end
            if (sample_q > max_q) begin
                max_q <= sample_q;
            end
        end
    end

    assign Min_Out = min_q;
    assign Max_Out = max_q;
`endif

endmodule

// File: doc/xadc_sample_monitor.md
Name: xadc_sample_monitor

Overview:
- Sits directly downstream of the XADC controller FSM.
- Paces conversions by issuing a periodic one-cycle trigger to the controller, then captures the returned 16-bit DRP word on the controller's data-valid strobe.
- Block-averages 2^AVG_LOG2 samples and compares the average against high/low thresholds with hysteresis.
- Results feed the monitoring/alarm logic and the status display.

Parameters:
- AVG_LOG2, 3, log2 of samples per block average (1..8).
- TRIG_PERIOD, 100000, Clk cycles between trigger pulses (>= 16).
- DATA_W, 12, XADC result width; sample = ADC_Data_in[15:16-DATA_W].

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  run monitoring when high
- trigger  out  1  one-cycle conversion start to controller
- Sample_Valid  in  1  one-cycle strobe; ADC_Data_in holds a new sample
- ADC_Data_in  in  16  DRP word from controller
- Thresh_Hi  in  DATA_W  alarm set level
- Thresh_Lo  in  DATA_W  alarm clear level
- Clear_Overrun  in  1  clears Overrun
- Avg_Out  out  DATA_W  latest block average
- Avg_Valid  out  1  one-cycle pulse when Avg_Out updates
- Alarm  out  1  hysteretic over-threshold flag
- Overrun  out  1  sticky: period elapsed with sample outstanding

Behaviour:
- Clk is the only clock. Reset is synchronous, active-high, and is sampled only on posedge Clk.
- Reset values: trigger=0, Avg_Out=0, Avg_Valid=0, Alarm=0, Overrun=0; period counter=0, accumulator=0, sample count=0, state=IDLE.
- Reset mid-operation returns the block to these values on the next edge. Any in-flight sample is discarded.
- Period counter:
  - Counts 0..TRIG_PERIOD-1 while Enable=1 and wraps. It is held at 0 while Enable=0.
  - The "tick" condition is the cycle where the count equals TRIG_PERIOD-1.
- FSM states IDLE, WT_TICK, TRIG, WT_SAMPLE, ACCUM, UPDATE:
  - IDLE: go to WT_TICK when Enable=1.
  - WT_TICK: on tick, go to TRIG.
  - TRIG: trigger=1 for exactly this cycle; go to WT_SAMPLE.
  - WT_SAMPLE: on Sample_Valid=1, register the sample and go to ACCUM.
    - If a tick occurs in the same cycle and Sample_Valid=0, set Overrun, emit no trigger, and stay in WT_SAMPLE.
    - If Sample_Valid and tick coincide, the sample wins and Overrun is not set.
  - ACCUM: add the sample to the accumulator and increment the count.
    - If count wraps to 0 (2^AVG_LOG2 samples collected), go to UPDATE; else go to WT_TICK.
  - UPDATE:
    - Avg_Out <= acc >> AVG_LOG2 (truncating).
    - Avg_Valid=1 this cycle only.
    - Accumulator is cleared. Go to WT_TICK.
- Sample_Valid outside WT_SAMPLE is ignored.
- Accumulator width is DATA_W+AVG_LOG2, so it never overflows. For example, 8 samples of 12'hFFF gives acc=15'h7FF8 and avg=12'hFFF.
- Alarm is evaluated in UPDATE using the new average:
  - avg > Thresh_Hi sets it.
  - Else avg < Thresh_Lo clears it.
  - Else it holds.
  - If Thresh_Lo > Thresh_Hi, the set condition has priority.
- Enable deasserted:
  - The FSM goes to IDLE on the next edge, and the accumulator, count and period counter clear.
  - Avg_Out, Alarm and Overrun hold.
  - A trigger already issued is abandoned; a late Sample_Valid is ignored.
- Overrun: Clear_Overrun=1 clears it. If a set event coincides with Clear_Overrun, set wins.

Optional Feature:
- Macro: XADC_MONITOR_MINMAX_EN.
- Defined:
  - Adds output ports Min_Out and Max_Out (DATA_W each).
  - These track the minimum and maximum raw samples accepted in ACCUM since Reset.
  - Reset values: Min_Out=all ones, Max_Out=0.
  - They update the cycle after ACCUM and are unaffected by Enable.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- TRIG_PERIOD=16, AVG_LOG2=2, Enable=1 after reset, each trigger answered 3 cycles later with Sample_Valid and samples 0x100,0x200,0x300,0x400 (in [15:4]) -> exactly 4 trigger pulses spaced 16 cycles; Avg_Valid pulses once; Avg_Out=0x280.
- Thresh_Hi=0x300, Thresh_Lo=0x100; block averages 0x350, 0x200, 0x0F0 -> Alarm 1, stays 1, then 0.
- Sample_Valid withheld for 40 cycles after a trigger (TRIG_PERIOD=16) -> Overrun=1 at first tick; no second trigger. Then Sample_Valid arrives -> accumulation resumes. Clear_Overrun -> Overrun=0.
- 8 samples of 0xFFF0 with AVG_LOG2=3 -> Avg_Out=0xFFF; no wrap.
- Reset asserted in WT_SAMPLE after 3 of 4 samples -> all outputs at reset values next cycle. A following full block averages only the new samples.
- MINMAX_EN build: samples 0x500,0x080,0x900 -> Min_Out=0x080, Max_Out=0x900.
